// File: rtl/aes_cbc_dec.sv
// AES-128 CBC decryption engine. A combinational inverse cipher (aes_decr) is evaluated
// as a multicycle path; the wrapper handles chaining, valid/ready handshakes and counting.

module aes_decr (
  input  logic         rst,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Field inverse as a^254, which maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, t;
    a2  = gf_mul(a, a);
    a3  = gf_mul(a2, a);
    a6  = gf_mul(a3, a3);
    a12 = gf_mul(a6, a6);
    t   = gf_mul(a12, a3);
    for (int i = 0; i < 4; i++) t = gf_mul(t, t);
    return gf_mul(gf_mul(t, a12), a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round key r sits at ks[128*r +: 128].
  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r)&3)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
        gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
        gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
        gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
    end
    return o;
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] c, input logic [127:0] k);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand_key(k);
    s  = c ^ ks[1280 +: 128];
    for (int r = 9; r >= 0; r--) begin
      s = inv_shift_sub(s) ^ ks[128*r +: 128];
      if (r != 0) s = inv_mix_columns(s);
    end
    return s;
  endfunction

  assign out = rst ? 128'h0 : decrypt(in, key);
endmodule

module aes_cbc_dec #(
  parameter int CORE_CYCLES = 2,
  parameter int BLK_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [127:0]         key,
  input  logic [127:0]         iv,
  input  logic                 iv_load,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  input  logic [127:0]         ct_data,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [127:0]         pt_data,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt
);
  localparam int WCNT_W = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t               r_state, w_next;
  logic [127:0]         r_chain, r_ct, r_key, r_pt_data, w_dec;
  logic                 r_pt_valid, w_accept, w_ct_ready;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic [WCNT_W-1:0]    r_wcnt;

  // ct_reg/key_reg are held for the whole of CALC, so the core path may span CORE_CYCLES.
  aes_decr u_core (.rst(1'b0), .in(r_ct), .key(r_key), .out(w_dec));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no branch can infer a latch.
    w_next     = r_state;
    w_ct_ready = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ct_ready = ~rst & ~iv_load;
        w_accept   = ct_valid & w_ct_ready;
        if (w_accept) w_next = S_CALC;
      end
      S_CALC:  if (r_wcnt == '0) w_next = S_OUT;
      S_OUT:   if (pt_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain    <= '0;
      r_ct       <= '0;
      r_key      <= '0;
      r_pt_data  <= '0;
      r_pt_valid <= 1'b0;
      r_blk_cnt  <= '0;
      r_wcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iv_load) begin
            r_chain   <= iv;
            r_blk_cnt <= '0;
          end else if (w_accept) begin
            r_ct   <= ct_data;
            r_key  <= key;
            r_wcnt <= WCNT_W'(CORE_CYCLES - 1);
          end
        end
        S_CALC: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - WCNT_W'(1);
          end else begin
            r_pt_data  <= w_dec ^ r_chain;
            r_chain    <= r_ct;
            r_pt_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (pt_ready) begin
            r_pt_valid <= 1'b0;
            r_blk_cnt  <= r_blk_cnt + BLK_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ct_ready = w_ct_ready;
  assign pt_valid = r_pt_valid;
  assign pt_data  = r_pt_data;
  assign blk_cnt  = r_blk_cnt;
  assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_aes_cbc_dec.sv
// Directed bench for aes_cbc_dec using the SP800-38A CBC-AES128 vectors plus
// hand-written backpressure, load-priority and mid-block reset sequences.

module tb_aes_cbc_dec;
  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] DC1 = 128'h6bc0bce12a459991e134741a7f9e1925;  // raw aes_decr(C1)
  localparam logic [127:0] DC2 = 128'hd86421fb9f1a1eda505ee1375746972c;  // raw aes_decr(C2)

  logic         clk = 1'b0;
  logic         rst, iv_load, ct_valid, pt_ready;
  logic [127:0] key, iv, ct_data;
  logic         ct_ready, pt_valid, busy;
  logic [127:0] pt_data;
  logic [31:0]  blk_cnt;

  aes_cbc_dec #(.CORE_CYCLES(2), .BLK_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .key(key), .iv(iv), .iv_load(iv_load),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           load;
    logic [127:0] iv;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           pulse;
  } vec_t;

  vec_t        tbl [7];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;
  int          seen;
  logic [31:0] exp_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv      = v;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    iv      = ~v;
  endtask

  // Offers one block, then returns the number of cycles from the accept cycle to pt_valid.
  task automatic run_block(input logic [127:0] ct, input bit pulse, output int lat_o);
    int n = 0;
    ct_valid = 1'b1;
    ct_data  = ct;
    key      = K;
    #1;
    while (!ct_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", ct_ready, 1'b1);
    tick();
    ct_valid = 1'b0;
    ct_data  = ~ct;
    key      = ~K;
    lat_o    = 1;
    if (pulse) begin
      iv      = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      iv_load = 1'b1;
      tick();
      iv_load = 1'b0;
      lat_o++;
    end
    while (!pt_valid && lat_o < 20) begin
      tick();
      lat_o++;
    end
  endtask

  task automatic handshake();
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, IV0,    C1, P1,  1'b0};
    tbl[1] = '{1'b0, '0,     C2, P2,  1'b0};
    tbl[2] = '{1'b0, '0,     C3, P3,  1'b0};
    tbl[3] = '{1'b1, '0,     C1, DC1, 1'b0};
    tbl[4] = '{1'b1, '0,     C2, DC2, 1'b0};
    tbl[5] = '{1'b1, C1,     C2, P2,  1'b1};
    tbl[6] = '{1'b0, '0,     C3, P3,  1'b0};

    rst = 1'b1; iv_load = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
    key = K; iv = '0; ct_data = '0;
    tick();
    check("rst_ct_ready", ct_ready, 1'b0);
    tick();
    check("rst_pt_valid", pt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_blk_cnt", blk_cnt, 32'd0);
    check("rst_ct_ready2", ct_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_ct_ready", ct_ready, 1'b1);

    exp_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].load) begin
        load_iv(tbl[i].iv);
        exp_cnt = '0;
      end
      run_block(tbl[i].ct, tbl[i].pulse, lat);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_pt", i), pt_data, tbl[i].pt);
      handshake();
      exp_cnt = exp_cnt + 32'd1;
      check($sformatf("v%0d_blk_cnt", i), blk_cnt, exp_cnt);
    end

    // Backpressure on P1.
    load_iv(IV0);
    run_block(C1, 1'b0, lat);
    check("bp_latency", lat, 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", pt_valid, 1'b1);
      check("bp_data", pt_data, P1);
      check("bp_ct_ready", ct_ready, 1'b0);
      check("bp_blk_cnt", blk_cnt, 32'd0);
    end
    check("bp_busy", busy, 1'b1);
    handshake();
    check("bp_release_valid", pt_valid, 1'b0);
    check("bp_release_cnt", blk_cnt, 32'd1);
    check("bp_data_held", pt_data, P1);
    tick(); tick(); tick();
    check("bp_single_handshake", blk_cnt, 32'd1);
    check("bp_idle", busy, 1'b0);

    // iv_load and ct_valid together in IDLE: load wins, block goes in next cycle.
    iv = IV0; iv_load = 1'b1; ct_valid = 1'b1; ct_data = C1; key = K;
    #1;
    check("sim_ct_ready", ct_ready, 1'b0);
    tick();
    iv_load = 1'b0;
    iv = '0;
    check("sim_cnt_cleared", blk_cnt, 32'd0);
    check("sim_not_accepted", busy, 1'b0);
    run_block(C1, 1'b0, lat);
    check("sim_latency", lat, 3);
    check("sim_pt", pt_data, P1);
    handshake();
    check("sim_blk_cnt", blk_cnt, 32'd1);

    // Reset while a block is in CALC.
    ct_valid = 1'b1; ct_data = C2; key = K;
    tick();
    ct_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_ct_ready", ct_ready, 1'b0);
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cnt", blk_cnt, 32'd0);
    check("mid_rst_valid", pt_valid, 1'b0);
    check("mid_rst_pt_data", pt_data, 128'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pt_valid) seen++;
    end
    check("mid_rst_no_output", seen, 0);
    run_block(C1, 1'b0, lat);
    check("zero_iv_latency", lat, 3);
    check("zero_iv_pt", pt_data, DC1);
    handshake();
    check("zero_iv_cnt", blk_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
